riscv_fetch_ctrl: RTL

//   Instruction-fetch sequencer between the PC and a handshaked instruction memory.

---
 rtl/riscv_constants.sv | 23 ++
 rtl/riscv_fetch_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/riscv_constants.sv
// Shared RISC-V front-end constants: PC source select and fetch sequencer states.
package riscv_constants;

    typedef enum logic [1:0] {
        PC_SEL_HOLD,
        PC_SEL_SEQ,
        PC_SEL_REDIRECT
    } pc_sel_t;

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HOLD
    } fetch_state_t;

    // Instruction fetch is word-aligned, so the low two address bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/riscv_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps one imem request in flight,
// hands words to decode over valid/ready and squashes stale responses on redirect.
module riscv_fetch_ctrl
    import riscv_constants::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        x_reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        busy
);

    fetch_state_t state, state_n;
    pc_sel_t      pc_sel;
    logic [31:0]  pc, pc_n;
    logic         load_inst;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_n   = state;
        pc_sel    = PC_SEL_HOLD;
        load_inst = 1'b0;

        unique case (state)
            S_BOOT: state_n = S_REQ;
            S_REQ: begin
                if (redirect_valid) pc_sel = PC_SEL_REDIRECT;
                if (imem_gnt)       state_n = redirect_valid ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_sel  = PC_SEL_REDIRECT;
                    state_n = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    load_inst = 1'b1;
                    state_n   = S_HOLD;
                end
            end
            // The in-flight response belongs to the old PC; swallow it before re-requesting.
            S_DRAIN: begin
                if (redirect_valid) pc_sel = PC_SEL_REDIRECT;
                if (imem_rvalid)    state_n = S_REQ;
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_sel  = PC_SEL_REDIRECT;
                    state_n = S_REQ;
                end else if (inst_ready) begin
                    pc_sel  = PC_SEL_SEQ;
                    state_n = S_REQ;
                end
            end
            default: state_n = S_BOOT;
        endcase

        unique case (pc_sel)
            PC_SEL_SEQ:      pc_n = pc + 32'(PC_STEP);
            PC_SEL_REDIRECT: pc_n = align_word(redirect_pc);
            default:         pc_n = pc;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (x_reset) begin
            state     <= S_BOOT;
            pc        <= RESET_PC;
            inst_data <= '0;
            inst_pc   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (load_inst) begin
                inst_data <= imem_rdata;
                inst_pc   <= pc;
            end
        end
    end

    assign imem_req   = (state == S_REQ);
    assign imem_addr  = pc;
    assign inst_valid = (state == S_HOLD);
    assign busy       = (state != S_BOOT);

endmodule
